// File: rtl/posit_unpack_pipe.sv
// -----------------------------------------------------------------------------
// posit_unpack_pipe
//   Two-stage pipelined posit field extractor. Feeds the one-hot decoder that
//   builds regime/fraction masks from out_rlen.
//
//   Stage 1 registers sign, zero/NaR flags and the two's-complement magnitude.
//   Stage 2 decodes regime run length, exponent and fraction from that
//   magnitude and registers the result fields.
//
// Parameters
//   N   posit width (>= 8)
//   ES  exponent field width (0..3)
//   RW = $clog2(N), SW = $clog2(N)+ES+1, FW = N-2-ES (derived)
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      input handshake, in_posit = N-bit posit word
//   out_valid/out_ready    output handshake
//   out_sign/zero/nar      sign bit, input==0, input==NaR
//   out_scale [SW]         signed scale k*2^ES + e
//   out_frac  [FW]         {1'b1, fraction}, left-aligned, zero-padded
//   out_rlen  [RW]         regime run length (0 for zero/NaR)
//   nar_sticky             only when POSIT_UNPACK_NAR_STICKY_EN is defined:
//                          set by an output transfer of a NaR, cleared by reset
// -----------------------------------------------------------------------------
module posit_unpack_pipe #(
    parameter  int N  = 16,
    parameter  int ES = 1,
    localparam int RW = $clog2(N),
    localparam int SW = $clog2(N) + ES + 1,
    localparam int FW = N - 2 - ES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_posit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic                 out_zero,
    output logic                 out_nar,
    output logic signed [SW-1:0] out_scale,
    output logic [FW-1:0]        out_frac,
    output logic [RW-1:0]        out_rlen
`ifdef POSIT_UNPACK_NAR_STICKY_EN
    ,
    output logic                 nar_sticky
`endif
);

    // ---------------- handshake ----------------
    logic w_s2_adv;
    logic w_s1_adv;

    logic r_s1_valid;
    logic r_out_valid;

    // Output stage moves when empty or being drained; stage 1 moves when
    // empty or when the output stage moves, so a full pipe still accepts a
    // word in the same cycle the consumer takes one.
    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // ---------------- stage 1 ----------------
    logic         r_s1_sign;
    logic         r_s1_zero;
    logic         r_s1_nar;
    logic [N-2:0] r_s1_mag;
    logic [N-2:0] w_mag;

    // Low N-1 bits of the negation depend only on the low N-1 input bits;
    // bit N-1 of the magnitude is only ever set for NaR, which is flagged.
    assign w_mag = in_posit[N-1] ? -in_posit[N-2:0] : in_posit[N-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_mag   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_posit[N-1];
                r_s1_zero <= (in_posit == '0);
                r_s1_nar  <= (in_posit == {1'b1, {(N-1){1'b0}}});
                r_s1_mag  <= w_mag;
            end
        end
    end

    // ---------------- stage 2 decode ----------------
    logic          w_r;
    logic          w_run;
    logic [RW-1:0] w_rlen;
    logic [RW-1:0] w_shamt;
    logic [N-4:0]  w_rem;
    logic signed [SW-1:0] w_rlen_s;
    logic signed [SW-1:0] w_k;
    logic signed [SW-1:0] w_e_ext;
    logic signed [SW-1:0] w_scale;
    logic [FW-1:0] w_frac;

    assign w_r = r_s1_mag[N-2];

    // Leading run length of bits equal to the regime bit.
    always_comb begin
        w_rlen = '0;
        w_run  = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (w_run && (r_s1_mag[i] == w_r))
                w_rlen = w_rlen + RW'(1);
            else
                w_run = 1'b0;
        end
    end

    // Regime plus terminator occupy rlen+1 bits starting at N-2, so the
    // exponent starts at bit N-3-rlen. Shifting the low N-3 bits left by
    // rlen-1 puts that bit at the top of w_rem; bits past the LSB shift in
    // as 0. Shift amounts >= N-3 empty the vector entirely.
    assign w_shamt = w_rlen - RW'(1);
    assign w_rem   = r_s1_mag[N-4:0] << w_shamt;

    generate
        if (ES > 0) begin : g_exp
            assign w_e_ext = SW'(w_rem[N-4 -: ES]);
        end else begin : g_noexp
            assign w_e_ext = '0;
        end
    endgenerate

    assign w_frac   = {1'b1, w_rem[N-4-ES:0]};
    assign w_rlen_s = {{(SW-RW){1'b0}}, w_rlen};
    assign w_k      = w_r ? (w_rlen_s - SW'(1)) : -w_rlen_s;
    assign w_scale  = (w_k <<< ES) + w_e_ext;

    // ---------------- stage 2 register ----------------
    logic                 r_sign;
    logic                 r_zero;
    logic                 r_nar;
    logic signed [SW-1:0] r_scale;
    logic [FW-1:0]        r_frac;
    logic [RW-1:0]        r_rlen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_nar       <= 1'b0;
            r_scale     <= '0;
            r_frac      <= '0;
            r_rlen      <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            // Fields only load with a real word so they hold their last
            // value across bubbles.
            if (r_s1_valid) begin
                r_sign <= r_s1_sign;
                r_zero <= r_s1_zero;
                r_nar  <= r_s1_nar;
                if (r_s1_zero || r_s1_nar) begin
                    r_scale <= '0;
                    r_frac  <= '0;
                    r_rlen  <= '0;
                end else begin
                    r_scale <= w_scale;
                    r_frac  <= w_frac;
                    r_rlen  <= w_rlen;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sign  = r_sign;
    assign out_zero  = r_zero;
    assign out_nar   = r_nar;
    assign out_scale = r_scale;
    assign out_frac  = r_frac;
    assign out_rlen  = r_rlen;

`ifdef POSIT_UNPACK_NAR_STICKY_EN
    logic r_nar_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_nar_sticky <= 1'b0;
        else if (r_out_valid && out_ready && r_nar)
            r_nar_sticky <= 1'b1;
    end

    assign nar_sticky = r_nar_sticky;
`endif

endmodule

// File: tb/tb_posit_unpack_pipe.sv
module tb_posit_unpack_pipe;
  localparam int N  = 16;
  localparam int ES = 1;
  localparam int RW = 4;
  localparam int SW = 6;
  localparam int FW = 13;

  logic                 clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]         in_posit;
  logic                 out_sign, out_zero, out_nar;
  logic signed [SW-1:0] out_scale;
  logic [FW-1:0]        out_frac;
  logic [RW-1:0]        out_rlen;
`ifdef POSIT_UNPACK_NAR_STICKY_EN
  logic                 nar_sticky;
`endif

  posit_unpack_pipe #(.N(N), .ES(ES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_zero(out_zero), .out_nar(out_nar),
    .out_scale(out_scale), .out_frac(out_frac), .out_rlen(out_rlen)
`ifdef POSIT_UNPACK_NAR_STICKY_EN
    , .nar_sticky(nar_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit sign; bit zero; bit nar;
    int scale; int frac; int rlen;
  } exp_t;
  typedef struct { logic [N-1:0] p; exp_t e; } vec_t;
  typedef struct { exp_t e; int cyc; } sb_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   mon_en = 0;
  bit   lat_chk = 0;
  sb_t  q[$];

  // Reference: walk the posit bit string position by position.
  function automatic exp_t ref_model(input logic [N-1:0] p);
    exp_t x;
    longint v, f;
    int idx, k, e, fb;
    bit r;
    x = '{default:0};
    x.sign = p[N-1];
    if (p == 0) begin x.zero = 1; return x; end
    if (p == (1 << (N-1))) begin x.nar = 1; return x; end
    v = x.sign ? (longint'(1) << N) - longint'(p) : longint'(p);
    idx = N - 2;
    r = bit'((v >> idx) & 1);
    while (idx >= 0 && (((v >> idx) & 1) == longint'(r))) begin
      x.rlen++;
      idx--;
    end
    k = r ? x.rlen - 1 : -x.rlen;
    idx--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2 + ((idx >= 0) ? int'((v >> idx) & 1) : 0);
      idx--;
    end
    fb = (idx >= 0) ? idx + 1 : 0;
    f  = v & ((longint'(1) << fb) - 1);
    x.frac  = (1 << (FW-1)) | int'(f << (FW-1-fb));
    x.scale = k * (1 << ES) + e;
    return x;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_fields(input string name, input exp_t e);
    checks++;
    if (out_sign !== e.sign || out_zero !== e.zero || out_nar !== e.nar ||
        int'(out_scale) != e.scale || int'(out_frac) != e.frac || int'(out_rlen) != e.rlen) begin
      failures++;
      $display("FAIL %s: got s=%0b z=%0b n=%0b sc=%0d fr=%h rl=%0d expected s=%0b z=%0b n=%0b sc=%0d fr=%h rl=%0d",
               name, out_sign, out_zero, out_nar, int'(out_scale), out_frac, out_rlen,
               e.sign, e.zero, e.nar, e.scale, e.frac[FW-1:0], e.rlen);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every accepted word must come out in order with the reference fields.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected: got output with empty queue, expected none");
        end else begin
          sb_t s;
          s = q.pop_front();
          chk_fields("sb_data", s.e);
          if (lat_chk) chk("sb_latency", cyc - s.cyc, 2);
        end
      end
      if (in_valid && in_ready) begin
        sb_t n;
        n.e = ref_model(in_posit);
        n.cyc = cyc;
        q.push_back(n);
      end
    end
  end

  task automatic push(input logic [N-1:0] w);
    bit ok;
    ok = 0;
    in_valid = 1; in_posit = w;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("push_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, q.size(), 0);
  endtask

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] sp [5];
    sp = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};
    if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 4)];
    return N'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [11];
    exp_t ea;
    bit   found;
    int   n0, stalls;

    tbl[0]  = '{16'h4000, '{0, 0, 0,   0, 13'h1000,  1}};
    tbl[1]  = '{16'h5000, '{0, 0, 0,   1, 13'h1000,  1}};
    tbl[2]  = '{16'h4800, '{0, 0, 0,   0, 13'h1800,  1}};
    tbl[3]  = '{16'h7FFF, '{0, 0, 0,  28, 13'h1000, 15}};
    tbl[4]  = '{16'h0001, '{0, 0, 0, -28, 13'h1000, 14}};
    tbl[5]  = '{16'h8000, '{1, 0, 1,   0, 0,         0}};
    tbl[6]  = '{16'hC000, '{1, 0, 0,   0, 13'h1000,  1}};
    tbl[7]  = '{16'h0000, '{0, 1, 0,   0, 0,         0}};
    tbl[8]  = '{16'h6000, '{0, 0, 0,   2, 13'h1000,  2}};
    tbl[9]  = '{16'h3000, '{0, 0, 0,  -1, 13'h1000,  1}};
    tbl[10] = '{16'hFFFF, '{1, 0, 0, -28, 13'h1000, 14}};

    rst_n = 0; in_valid = 0; in_posit = '0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fields", {out_sign, out_zero, out_nar, out_scale, out_frac, out_rlen}, 0);
`ifdef POSIT_UNPACK_NAR_STICKY_EN
    chk("rst_sticky", nar_sticky, 0);
`endif
    rst_n = 1; mon_en = 1;
    @(posedge clk); #1;

    // Directed table, constants worked out by hand.
    foreach (tbl[i]) begin
      push(tbl[i].p);
      found = 0;
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        if (out_valid) begin found = 1; break; end
      end
      chk("tbl_valid", found, 1);
      if (found) chk_fields($sformatf("tbl_%h", tbl[i].p), tbl[i].e);
      @(posedge clk); #1;
    end
`ifdef POSIT_UNPACK_NAR_STICKY_EN
    chk("sticky_held", nar_sticky, 1);
`endif

    // Back-pressure: two words fill the pipe, the third must wait.
    out_ready = 0;
    push(16'h5000);
    push(16'hC000);
    ea = tbl[1].e;
    in_valid = 1; in_posit = 16'h7FFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk_fields("stall_hold", ea);
    end
    n0 = n_out;
    @(posedge clk); #1;
    out_ready = 1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin found = 1; break; end
    end
    chk("stall_release_accept", found, 1);
    @(posedge clk); #1;
    in_valid = 0;
    drain("stall_drain");
    chk("stall_out_count", n_out - n0, 3);

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_posit  = rand_word();
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    drain("rand_drain");

    // Unstalled stream: one word per clock, latency 2.
    lat_chk = 1; n0 = n_out; stalls = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1; in_posit = rand_word();
      @(negedge clk);
      if (!in_ready) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    drain("stream_drain");
    lat_chk = 0;
    chk("stream_stalls", stalls, 0);
    chk("stream_count", n_out - n0, 100);

    // Reset with two words in flight.
    out_ready = 0;
    push(16'h4000);
    push(16'h6000);
    @(negedge clk);
    rst_n = 0; mon_en = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_fields", {out_sign, out_zero, out_nar, out_scale, out_frac, out_rlen}, 0);
`ifdef POSIT_UNPACK_NAR_STICKY_EN
    chk("midrst_sticky", nar_sticky, 0);
`endif
    q.delete();
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1; mon_en = 1; n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    push(16'hC000);
    drain("postrst_drain");
    chk("postrst_count", n_out - n0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
